// File: rtl/muldiv_unit_if.sv
// Handshake and result bundle between the EX stage and the multiply/divide unit.
interface muldiv_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             op;
    logic             Sign;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             hi_we;
    logic             lo_we;
    logic [WIDTH-1:0] wdata;
    logic             busy;
    logic             done;
    logic             div_by_zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, Sign, A, B, hi_we, lo_we, wdata,
        input  busy, done, div_by_zero, hi, lo
    );

    modport slave (
        input  start, op, Sign, A, B, hi_we, lo_we, wdata,
        output busy, done, div_by_zero, hi, lo
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with HI/LO registers: radix-2 shift-add
// multiply, restoring divide, one result bit per cycle, sign fix-up at the end.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic         clk,
    input  logic         reset,
    muldiv_unit_if.slave bus
);
    localparam int            CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t             state, state_d;
    logic               busy_q, done_q, dz_q;
    logic               busy_d, done_d, dz_d;

    // acc holds {partial product high, multiplier} for multiply and
    // {partial remainder, dividend/quotient} for divide
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   opb;
    logic [CW-1:0]      cnt;
    logic               op_q, neg_res, neg_rem, dz_op;
    logic [WIDTH-1:0]   hi_q, lo_q;

    logic               div_zero_req;
    logic [WIDTH-1:0]   abs_a, abs_b;
    logic [WIDTH:0]     mul_sum, div_shift, div_trial;
    logic [2*WIDTH-1:0] step_acc;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix, fix_hi, fix_lo;

    assign div_zero_req = bus.op && (bus.B == '0);
    assign abs_a        = (bus.Sign && bus.A[WIDTH-1]) ? -bus.A : bus.A;
    assign abs_b        = (bus.Sign && bus.B[WIDTH-1]) ? -bus.B : bus.B;

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.div_by_zero = dz_q;
    assign bus.hi          = hi_q;
    assign bus.lo          = lo_q;

    // State register and registered status flags
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            dz_q   <= 1'b0;
        end else begin
            state  <= state_d;
            busy_q <= busy_d;
            done_q <= done_d;
            dz_q   <= dz_d;
        end
    end

    // Next-state logic; busy/done/div_by_zero are precomputed for the next cycle
    always_comb begin
        state_d = state;
        done_d  = 1'b0;
        dz_d    = 1'b0;
        case (state)
            IDLE: if (bus.start) state_d = div_zero_req ? FIX : CALC;
            CALC: if (cnt == LAST) state_d = FIX;
            FIX: begin
                state_d = IDLE;
                done_d  = 1'b1;
                dz_d    = dz_op;
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    // One iteration of either shift-add multiply or restoring divide
    always_comb begin
        mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opb} : '0);
        div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        div_trial = div_shift - {1'b0, opb};
        if (op_q) begin
            if (!div_trial[WIDTH])
                step_acc = {div_trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
            else
                step_acc = {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
        end else begin
            step_acc = {mul_sum, acc[WIDTH-1:1]};
        end
    end

    // Sign correction and result selection applied on the FIX edge
    always_comb begin
        prod_fix = neg_res ? -acc : acc;
        quo_fix  = neg_res ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        rem_fix  = neg_rem ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
        if (dz_op) begin
            fix_hi = acc[WIDTH-1:0];
            fix_lo = '1;
        end else if (op_q) begin
            fix_hi = rem_fix;
            fix_lo = quo_fix;
        end else begin
            {fix_hi, fix_lo} = prod_fix;
        end
    end

    // Operand capture, iteration datapath and HI/LO register writes
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc     <= '0;
            opb     <= '0;
            cnt     <= '0;
            op_q    <= 1'b0;
            neg_res <= 1'b0;
            neg_rem <= 1'b0;
            dz_op   <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        op_q    <= bus.op;
                        dz_op   <= div_zero_req;
                        neg_res <= bus.Sign & (bus.A[WIDTH-1] ^ bus.B[WIDTH-1]);
                        neg_rem <= bus.Sign & bus.A[WIDTH-1];
                        // divide-by-zero keeps the raw dividend so HI returns A unchanged
                        acc     <= {{WIDTH{1'b0}}, (div_zero_req ? bus.A : abs_a)};
                        opb     <= abs_b;
                        cnt     <= '0;
                    end else begin
                        if (bus.hi_we) hi_q <= bus.wdata;
                        if (bus.lo_we) lo_q <= bus.wdata;
                    end
                end
                CALC: begin
                    acc <= step_acc;
                    cnt <= cnt + 1'b1;
                end
                FIX: begin
                    hi_q <= fix_hi;
                    lo_q <= fix_lo;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// Randomized bench for muldiv_unit at WIDTH=32 and WIDTH=8 against an
// arithmetic reference model.
module tb_muldiv_unit;
    logic clk = 1'b0;
    logic reset;

    int unsigned vectors     = 0;
    int unsigned miscompares = 0;

    logic [31:0] exp_hi [2];
    logic [31:0] exp_lo [2];

    always #5 clk = ~clk;

    muldiv_unit_if #(.WIDTH(32)) b32 ();
    muldiv_unit_if #(.WIDTH(8))  b8  ();

    muldiv_unit #(.WIDTH(32)) dut32 (.clk(clk), .reset(reset), .bus(b32));
    muldiv_unit #(.WIDTH(8))  dut8  (.clk(clk), .reset(reset), .bus(b8));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Reference: plain signed/unsigned arithmetic on wide integers
    function automatic void model(input int unsigned w, input bit op, input bit sgn,
                                  input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] ehi, output logic [31:0] elo,
                                  output bit edz);
        logic signed [127:0] va, vb, p, q, r;
        logic [127:0] mask, tmp;
        mask = (128'd1 << w) - 128'd1;
        va = {96'b0, a};
        vb = {96'b0, b};
        if (sgn && a[w-1]) va = va - (128'sd1 <<< w);
        if (sgn && b[w-1]) vb = vb - (128'sd1 <<< w);
        edz = 1'b0;
        if (!op) begin
            p   = va * vb;
            tmp = p >> w;
            ehi = tmp[31:0] & mask[31:0];
            elo = p[31:0] & mask[31:0];
        end else if (vb == 0) begin
            edz = 1'b1;
            ehi = a;
            elo = mask[31:0];
        end else begin
            q   = va / vb;
            r   = va % vb;
            ehi = r[31:0] & mask[31:0];
            elo = q[31:0] & mask[31:0];
        end
    endfunction

    function automatic logic [31:0] o_hi(input bit w8);
        return w8 ? {24'b0, b8.hi} : b32.hi;
    endfunction
    function automatic logic [31:0] o_lo(input bit w8);
        return w8 ? {24'b0, b8.lo} : b32.lo;
    endfunction
    function automatic logic o_busy(input bit w8);
        return w8 ? b8.busy : b32.busy;
    endfunction
    function automatic logic o_done(input bit w8);
        return w8 ? b8.done : b32.done;
    endfunction
    function automatic logic o_dz(input bit w8);
        return w8 ? b8.div_by_zero : b32.div_by_zero;
    endfunction

    task automatic set_in(input bit w8, input bit st, input bit op, input bit sgn,
                          input logic [31:0] a, input logic [31:0] b);
        if (w8) begin
            b8.start = st; b8.op = op; b8.Sign = sgn; b8.A = a[7:0]; b8.B = b[7:0];
        end else begin
            b32.start = st; b32.op = op; b32.Sign = sgn; b32.A = a; b32.B = b;
        end
    endtask

    function automatic logic [31:0] pick(input bit w8);
        logic [31:0] r;
        case ($urandom_range(0, 5))
            0: r = 32'h0;
            1: r = 32'hFFFFFFFF;
            2: r = w8 ? 32'h80 : 32'h80000000;
            3: r = 32'h1;
            default: r = $urandom;
        endcase
        if (w8) r = r & 32'hFF;
        return r;
    endfunction

    // Called at a negedge; returns at the negedge where done is visible
    task automatic run_op(input bit w8, input bit op, input bit sgn,
                          input logic [31:0] ain, input logic [31:0] bin, input string tag);
        int unsigned w, n, busy_n, lat;
        logic [31:0] a, b, ehi, elo;
        bit edz, held;
        w = w8 ? 8 : 32;
        a = w8 ? (ain & 32'hFF) : ain;
        b = w8 ? (bin & 32'hFF) : bin;
        model(w, op, sgn, a, b, ehi, elo, edz);
        lat = (op && b == 32'h0) ? 1 : w + 1;
        set_in(w8, 1'b1, op, sgn, a, b);
        @(negedge clk);
        set_in(w8, 1'b0, 1'($urandom), 1'($urandom), $urandom, $urandom);
        n = 0;
        busy_n = 0;
        held = 1'b1;
        while (!o_done(w8) && n < 100) begin
            if (o_busy(w8)) busy_n++;
            if (o_hi(w8) !== exp_hi[w8] || o_lo(w8) !== exp_lo[w8]) held = 1'b0;
            @(negedge clk);
            n++;
        end
        check({tag, " latency"}, n, lat);
        check({tag, " busy_cycles"}, busy_n, lat);
        check({tag, " hold"}, 32'(held), 32'd1);
        check({tag, " busy_at_done"}, 32'(o_busy(w8)), 32'd0);
        check({tag, " hi"}, o_hi(w8), ehi);
        check({tag, " lo"}, o_lo(w8), elo);
        check({tag, " dz"}, 32'(o_dz(w8)), 32'(edz));
        exp_hi[w8] = ehi;
        exp_lo[w8] = elo;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        set_in(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        set_in(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        b32.hi_we = 1'b0; b32.lo_we = 1'b0; b32.wdata = '0;
        b8.hi_we  = 1'b0; b8.lo_we  = 1'b0; b8.wdata  = '0;
        exp_hi[0] = 32'h0; exp_lo[0] = 32'h0;
        exp_hi[1] = 32'h0; exp_lo[1] = 32'h0;
        repeat (2) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            check("rst busy", 32'(o_busy(k[0])), 32'd0);
            check("rst done", 32'(o_done(k[0])), 32'd0);
            check("rst dz",   32'(o_dz(k[0])),   32'd0);
            check("rst hi",   o_hi(k[0]), 32'h0);
            check("rst lo",   o_lo(k[0]), 32'h0);
        end
        reset = 1'b0;
        @(negedge clk);

        run_op(1'b0, 1'b0, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, "mulu_max");
        check("mulu_max hi_const", b32.hi, 32'hFFFFFFFE);
        check("mulu_max lo_const", b32.lo, 32'h00000001);
        run_op(1'b0, 1'b0, 1'b1, 32'hFFFFFFFD, 32'd7, "mul_neg");
        run_op(1'b0, 1'b1, 1'b1, 32'hFFFFFFF9, 32'd2, "div_neg");
        run_op(1'b0, 1'b1, 1'b1, 32'h80000000, 32'hFFFFFFFF, "div_ovf");
        run_op(1'b0, 1'b1, 1'b0, 32'd100, 32'd7, "divu");
        run_op(1'b0, 1'b1, 1'b0, 32'h00001234, 32'h0, "div_zero");
        check("div_zero hi_const", b32.hi, 32'h00001234);
        check("div_zero lo_const", b32.lo, 32'hFFFFFFFF);
        @(negedge clk);
        check("done_pulse", 32'(b32.done), 32'd0);
        check("dz_pulse", 32'(b32.div_by_zero), 32'd0);

        // MTHI / MTLO writes in IDLE
        b32.hi_we = 1'b1; b32.wdata = 32'hCAFEF00D;
        @(negedge clk);
        b32.hi_we = 1'b0;
        exp_hi[0] = 32'hCAFEF00D;
        check("mthi", b32.hi, exp_hi[0]);
        b32.hi_we = 1'b1; b32.lo_we = 1'b1; b32.wdata = 32'h12345678;
        @(negedge clk);
        b32.hi_we = 1'b0; b32.lo_we = 1'b0;
        exp_hi[0] = 32'h12345678; exp_lo[0] = 32'h12345678;
        check("mthi_both", b32.hi, exp_hi[0]);
        check("mtlo_both", b32.lo, exp_lo[0]);

        // write coincident with start is dropped; start/write while busy ignored
        set_in(1'b0, 1'b1, 1'b0, 1'b0, 32'd1000, 32'd3);
        b32.lo_we = 1'b1; b32.wdata = 32'hDEADBEEF;
        @(negedge clk);
        set_in(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        b32.lo_we = 1'b0;
        check("mtlo_vs_start", b32.lo, exp_lo[0]);
        repeat (4) @(negedge clk);
        set_in(1'b0, 1'b1, 1'b1, 1'b0, 32'd9, 32'd9);
        b32.lo_we = 1'b1; b32.wdata = 32'h00000BAD;
        @(negedge clk);
        set_in(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        b32.lo_we = 1'b0;
        check("busy_keeps", 32'(b32.busy), 32'd1);
        check("mtlo_busy", b32.lo, exp_lo[0]);
        repeat (3) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("abort busy", 32'(b32.busy), 32'd0);
        check("abort hi", b32.hi, 32'h0);
        check("abort lo", b32.lo, 32'h0);
        exp_hi[0] = 32'h0; exp_lo[0] = 32'h0;
        exp_hi[1] = 32'h0; exp_lo[1] = 32'h0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        run_op(1'b0, 1'b0, 1'b0, 32'd6, 32'd7, "mul_6x7");
        check("mul_6x7 lo_const", b32.lo, 32'd42);

        // WIDTH=8: most-negative squared, then back-to-back start in the done cycle
        run_op(1'b1, 1'b0, 1'b1, 32'h80, 32'h80, "mul8_min");
        check("mul8_min hi_const", 32'(b8.hi), 32'h40);
        check("mul8_min lo_const", 32'(b8.lo), 32'h00);
        run_op(1'b1, 1'b1, 1'b1, 32'h80, 32'hFF, "b2b_div8");
        run_op(1'b1, 1'b1, 1'b0, 32'd200, 32'd0, "b2b_dz8");

        for (int i = 0; i < 60; i++) begin
            bit w8;
            w8 = i[0];
            run_op(w8, 1'($urandom), 1'($urandom), pick(w8), pick(w8), "rand");
            if ($urandom_range(0, 1) == 1) begin
                @(negedge clk);
                check("rand done_pulse", 32'(o_done(w8)), 32'd0);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
